// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS core pipeline control.
// PC source encodings, FSM states and HI/LO latencies.
package cpu_defs;

    localparam logic [1:0] PC_SEL_NORM    = 2'd0;
    localparam logic [1:0] PC_SEL_HANDLER = 2'd1;
    localparam logic [1:0] PC_SEL_EPC     = 2'd2;

    localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/hazard_unit.sv
// Combinational register and HI/LO hazard detection for the D stage.
// A Tuse of 3 can never be below a 2-bit Tnew, so unused sources never hazard.
module hazard_unit
    import cpu_defs::*;
(
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic       D_md,
    input  logic [4:0] E_A3,
    input  logic [4:0] M_A3,
    input  logic       E_RegWrite,
    input  logic       M_RegWrite,
    input  logic [1:0] E_tnew,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       md_busy,
    output logic       haz_E,
    output logic       haz_M,
    output logic       haz_md
);

    logic e_live;
    logic m_live;

    assign e_live = E_RegWrite && (E_A3 != 5'd0) && (E_tnew != 2'd0);
    assign m_live = M_RegWrite && (M_A3 != 5'd0) && (M_tnew != 2'd0);

    assign haz_E = e_live &&
        (((E_A3 == D_rs) && (D_tuse_rs < E_tnew)) ||
         ((E_A3 == D_rt) && (D_tuse_rt < E_tnew)));

    assign haz_M = m_live &&
        (((M_A3 == D_rs) && (D_tuse_rs < M_tnew)) ||
         ((M_A3 == D_rt) && (D_tuse_rt < M_tnew)));

    assign haz_md = D_md && (md_busy || E_md_start);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall/bubble/flush, PC source select,
// HI/LO busy counter and exception/interrupt sequencing.
module pipe_ctrl
    import cpu_defs::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic       D_md,
    input  logic [4:0] E_A3,
    input  logic [4:0] M_A3,
    input  logic       E_RegWrite,
    input  logic       M_RegWrite,
    input  logic [1:0] E_tnew,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_div,
    input  logic       M_valid,
    input  logic       M_exc,
    input  logic       M_eret,
    input  logic       int_req,
    input  logic       IE,
    output logic       stall,
    output logic       bubble_E,
    output logic       flush,
    output logic [1:0] pc_sel,
    output logic       exc_take,
    output logic       md_busy
);

    ctrl_state_e state;
    ctrl_state_e state_n;
    logic [3:0]  count;
    logic        int_pend;
    logic        haz_E;
    logic        haz_M;
    logic        haz_md;

    hazard_unit u_hazard (
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_md       (D_md),
        .E_A3       (E_A3),
        .M_A3       (M_A3),
        .E_RegWrite (E_RegWrite),
        .M_RegWrite (M_RegWrite),
        .E_tnew     (E_tnew),
        .M_tnew     (M_tnew),
        .E_md_start (E_md_start),
        .md_busy    (md_busy),
        .haz_E      (haz_E),
        .haz_M      (haz_M),
        .haz_md     (haz_md)
    );

    assign md_busy  = (count != 4'd0);
    assign stall    = (haz_E || haz_M || haz_md) && !flush;
    assign bubble_E = stall;

    always_comb begin
        state_n  = state;
        flush    = 1'b0;
        pc_sel   = PC_SEL_NORM;
        exc_take = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (M_exc || (int_pend && M_valid)) begin
                    flush    = 1'b1;
                    pc_sel   = PC_SEL_HANDLER;
                    exc_take = 1'b1;
                    state_n  = ST_RECOVER;
                end else if (M_eret) begin
                    flush  = 1'b1;
                    pc_sel = PC_SEL_EPC;
                end
            end
            // M holds the bubble left by the flush; nothing there is real.
            ST_RECOVER: begin
                state_n = ST_RUN;
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state    <= ST_RUN;
            count    <= 4'd0;
            int_pend <= 1'b0;
        end else begin
            state    <= state_n;
            int_pend <= (int_pend && !exc_take) || (int_req && IE);
            if (E_md_start) begin
                count <= E_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
            end else if (count != 4'd0) begin
                count <= count - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push
// expected outputs, a negedge monitor pops and compares them.
module tb_pipe_ctrl;

    logic       CLK;
    logic       reset;
    logic [4:0] D_rs, D_rt;
    logic [1:0] D_tuse_rs, D_tuse_rt;
    logic       D_md;
    logic [4:0] E_A3, M_A3;
    logic       E_RegWrite, M_RegWrite;
    logic [1:0] E_tnew, M_tnew;
    logic       E_md_start, E_md_div;
    logic       M_valid, M_exc, M_eret;
    logic       int_req, IE;
    logic       stall, bubble_E, flush;
    logic [1:0] pc_sel;
    logic       exc_take, md_busy;

    typedef struct {
        logic       stall;
        logic       bubble;
        logic       flush;
        logic [1:0] pc;
        logic       exc;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_fail;

    pipe_ctrl dut (
        .CLK        (CLK),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_md       (D_md),
        .E_A3       (E_A3),
        .M_A3       (M_A3),
        .E_RegWrite (E_RegWrite),
        .M_RegWrite (M_RegWrite),
        .E_tnew     (E_tnew),
        .M_tnew     (M_tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .M_valid    (M_valid),
        .M_exc      (M_exc),
        .M_eret     (M_eret),
        .int_req    (int_req),
        .IE         (IE),
        .stall      (stall),
        .bubble_E   (bubble_E),
        .flush      (flush),
        .pc_sel     (pc_sel),
        .exc_take   (exc_take),
        .md_busy    (md_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input string fld,
                       input logic [1:0] act, input logic [1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", tag, fld, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "stall",    {1'b0, stall},    {1'b0, e.stall});
            chk(e.tag, "bubble_E", {1'b0, bubble_E}, {1'b0, e.bubble});
            chk(e.tag, "flush",    {1'b0, flush},    {1'b0, e.flush});
            chk(e.tag, "pc_sel",   pc_sel,           e.pc);
            chk(e.tag, "exc_take", {1'b0, exc_take}, {1'b0, e.exc});
            chk(e.tag, "md_busy",  {1'b0, md_busy},  {1'b0, e.busy});
        end
    end

    task automatic idle();
        D_rs = 5'd0; D_rt = 5'd0;
        D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        D_md = 1'b0;
        E_A3 = 5'd0; M_A3 = 5'd0;
        E_RegWrite = 1'b0; M_RegWrite = 1'b0;
        E_tnew = 2'd0; M_tnew = 2'd0;
        E_md_start = 1'b0; E_md_div = 1'b0;
        M_valid = 1'b1; M_exc = 1'b0; M_eret = 1'b0;
        int_req = 1'b0; IE = 1'b0;
    endtask

    // Queue the expected outputs for the inputs now applied, then advance.
    task automatic cyc(input string tag, input logic s, input logic f,
                       input logic [1:0] p, input logic x, input logic b);
        exp_t e;
        e.stall = s; e.bubble = s; e.flush = f;
        e.pc = p; e.exc = x; e.busy = b; e.tag = tag;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        idle();
        reset = 1'b0;
        @(posedge CLK);
        #1;
        cyc("reset0", 0, 0, 0, 0, 0);
        cyc("reset1", 0, 0, 0, 0, 0);
        reset = 1'b1;

        // load-use: lw $1 in E, consumer in D
        E_RegWrite = 1; E_A3 = 5'd1; E_tnew = 2'd2;
        D_rs = 5'd1; D_tuse_rs = 2'd1;
        cyc("lw_E", 1, 0, 0, 0, 0);
        idle();
        M_RegWrite = 1; M_A3 = 5'd1; M_tnew = 2'd1;
        D_rs = 5'd1; D_tuse_rs = 2'd1;
        cyc("lw_M", 0, 0, 0, 0, 0);
        idle();
        E_RegWrite = 1; E_A3 = 5'd0; E_tnew = 2'd2;
        D_rs = 5'd0; D_tuse_rs = 2'd0;
        cyc("r0", 0, 0, 0, 0, 0);
        idle();
        E_RegWrite = 1; E_A3 = 5'd5; E_tnew = 2'd1;
        D_rt = 5'd5; D_tuse_rt = 2'd0;
        cyc("rt_E", 1, 0, 0, 0, 0);
        idle();
        M_RegWrite = 1; M_A3 = 5'd7; M_tnew = 2'd2;
        D_rs = 5'd7; D_tuse_rs = 2'd1;
        cyc("rs_M", 1, 0, 0, 0, 0);
        idle();
        E_RegWrite = 1; E_A3 = 5'd9; E_tnew = 2'd3;
        D_rs = 5'd9; D_tuse_rs = 2'd3;
        cyc("tuse3", 0, 0, 0, 0, 0);
        E_RegWrite = 0;
        cyc("nowrite", 0, 0, 0, 0, 0);

        // div with dependent HI/LO reader in D
        idle();
        E_md_start = 1; E_md_div = 1; D_md = 1;
        cyc("div_t0", 1, 0, 0, 0, 0);
        idle();
        D_md = 1;
        for (int i = 1; i <= 10; i++) cyc("div_busy", 1, 0, 0, 0, 1);
        cyc("div_done", 0, 0, 0, 0, 0);

        // mult, reloaded by a div two cycles in
        idle();
        E_md_start = 1;
        cyc("mul_t0", 0, 0, 0, 0, 0);
        idle();
        cyc("mul_t1", 0, 0, 0, 0, 1);
        cyc("mul_t2", 0, 0, 0, 0, 1);
        E_md_start = 1; E_md_div = 1;
        cyc("reload", 0, 0, 0, 0, 1);
        idle();
        for (int i = 0; i < 10; i++) cyc("reload_busy", 0, 0, 0, 0, 1);
        cyc("reload_done", 0, 0, 0, 0, 0);

        // exception masks hazard, then RECOVER ignores a second one
        idle();
        E_RegWrite = 1; E_A3 = 5'd1; E_tnew = 2'd2;
        D_rs = 5'd1; D_tuse_rs = 2'd1;
        M_exc = 1;
        cyc("exc", 0, 1, 1, 1, 0);
        cyc("recover", 1, 0, 0, 0, 0);
        idle();
        cyc("post_exc", 0, 0, 0, 0, 0);

        // interrupt held until M is valid
        M_valid = 0; IE = 1; int_req = 1;
        cyc("irq_req", 0, 0, 0, 0, 0);
        int_req = 0;
        cyc("irq_wait1", 0, 0, 0, 0, 0);
        cyc("irq_wait2", 0, 0, 0, 0, 0);
        M_valid = 1;
        cyc("irq_take", 0, 1, 1, 1, 0);
        cyc("irq_recov", 0, 0, 0, 0, 0);
        cyc("irq_clear", 0, 0, 0, 0, 0);
        IE = 0; int_req = 1;
        cyc("irq_ie0a", 0, 0, 0, 0, 0);
        int_req = 0;
        cyc("irq_ie0b", 0, 0, 0, 0, 0);
        cyc("irq_ie0c", 0, 0, 0, 0, 0);

        // eret, then eret with exception
        idle();
        M_eret = 1;
        cyc("eret", 0, 1, 2, 0, 0);
        M_exc = 1;
        cyc("eret_exc", 0, 1, 1, 1, 0);
        idle();
        cyc("eret_rec", 0, 0, 0, 0, 0);

        // reset while busy (count 7) and in RECOVER
        E_md_start = 1; E_md_div = 1;
        cyc("rst_t0", 0, 0, 0, 0, 0);
        idle();
        cyc("rst_c10", 0, 0, 0, 0, 1);
        cyc("rst_c9", 0, 0, 0, 0, 1);
        M_exc = 1;
        cyc("rst_exc", 0, 1, 1, 1, 1);
        idle();
        reset = 0;
        cyc("rst_low", 0, 0, 0, 0, 1);
        reset = 1;
        cyc("rst_after", 0, 0, 0, 0, 0);
        cyc("rst_after2", 0, 0, 0, 0, 0);

        @(negedge CLK);
        @(negedge CLK);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
